// File: rtl/reg16_bus_pkg.sv
// reg16_bus_pkg: shared types and strobe constants for the
// 16-bit latch-pair bus controller.
package reg16_bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WLO_SET,
        WLO_STB,
        WHI_SET,
        WHI_STB,
        RLO,
        RHI,
        TURN,
        RSP
    } state_t;

    localparam logic N_OE_OFF = 1'b1;
    localparam logic CLK_IDLE = 1'b0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_wait_cnt.sv
// bus_wait_cnt: loadable down-counter that flags the last
// cycle of a settle or turnaround wait.
module bus_wait_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] cnt;

    // load wins over counting; hold at zero once expired
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = en && (cnt == '0);

endmodule

// File: rtl/reg16_bus_ctrl.sv
// reg16_bus_ctrl: turns 16-bit read/write requests into the strobe
// sequence for two 8-bit tristate latches on a shared bus.
module reg16_bus_ctrl
    import reg16_bus_pkg::*;
#(
    parameter int SETTLE     = 1,
    parameter int TURNAROUND = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic [15:0] REQ_DATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [15:0] RSP_DATA,
    output logic [7:0]  BUS_OUT,
    output logic        BUS_OE,
    input  logic [7:0]  BUS_IN,
    output logic        LATCH_CLK1,
    output logic        LATCH_CLK2,
    output logic        LATCH_N_OE1,
    output logic        LATCH_N_OE2
);
    localparam int CW = $clog2(max2(SETTLE, TURNAROUND)) + 1;
    localparam logic [CW-1:0] SET_V  = CW'(SETTLE);
    localparam logic [CW-1:0] TURN_V = CW'(TURNAROUND - 1);

    state_t        state;
    state_t        state_nx;
    logic          turn_rhi;
    logic          turn_rhi_nx;
    logic [15:0]   data_q;
    logic          accept;
    logic          cnt_load;
    logic          cnt_en;
    logic          cnt_done;
    logic [CW-1:0] cnt_val;
    logic          oe_nx;
    logic          clk1_nx;
    logic          clk2_nx;
    logic          noe1_nx;
    logic          noe2_nx;
    logic          valid_nx;
    logic [7:0]    out_nx;

    assign REQ_READY = (state == IDLE) && !RST;
    assign accept    = REQ_VALID && REQ_READY;

    bus_wait_cnt #(.W(CW)) u_wait (
        .clk   (CLK),
        .rst   (RST),
        .load  (cnt_load),
        .value (cnt_val),
        .en    (cnt_en),
        .done  (cnt_done)
    );

    // state, turnaround return flag and captured write data
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            turn_rhi <= 1'b0;
            data_q   <= '0;
        end else begin
            state    <= state_nx;
            turn_rhi <= turn_rhi_nx;
            if (accept) begin
                data_q <= REQ_DATA;
            end
        end
    end

    // next state, wait counter control and next output values
    always_comb begin
        state_nx    = state;
        turn_rhi_nx = turn_rhi;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        cnt_en      = 1'b0;
        oe_nx       = 1'b0;
        out_nx      = BUS_OUT;
        clk1_nx     = CLK_IDLE;
        clk2_nx     = CLK_IDLE;
        noe1_nx     = N_OE_OFF;
        noe2_nx     = N_OE_OFF;
        valid_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (REQ_WRITE) begin
                        state_nx = WLO_SET;
                    end else begin
                        state_nx = RLO;
                        cnt_load = 1'b1;
                        cnt_val  = SET_V;
                    end
                end
            end
            WLO_SET: begin
                oe_nx    = 1'b1;
                out_nx   = data_q[7:0];
                state_nx = WLO_STB;
            end
            WLO_STB: begin
                oe_nx    = 1'b1;
                out_nx   = data_q[7:0];
                clk1_nx  = 1'b1;
                state_nx = WHI_SET;
            end
            WHI_SET: begin
                oe_nx    = 1'b1;
                out_nx   = data_q[15:8];
                state_nx = WHI_STB;
            end
            WHI_STB: begin
                oe_nx       = 1'b1;
                out_nx      = data_q[15:8];
                clk2_nx     = 1'b1;
                state_nx    = TURN;
                cnt_load    = 1'b1;
                cnt_val     = TURN_V;
                turn_rhi_nx = 1'b0;
            end
            RLO: begin
                noe1_nx = 1'b0;
                cnt_en  = 1'b1;
                if (cnt_done) begin
                    state_nx    = TURN;
                    cnt_load    = 1'b1;
                    cnt_val     = TURN_V;
                    turn_rhi_nx = 1'b1;
                end
            end
            RHI: begin
                noe2_nx = 1'b0;
                cnt_en  = 1'b1;
                if (cnt_done) begin
                    state_nx    = TURN;
                    cnt_load    = 1'b1;
                    cnt_val     = TURN_V;
                    turn_rhi_nx = 1'b0;
                end
            end
            TURN: begin
                cnt_en = 1'b1;
                if (cnt_done) begin
                    if (turn_rhi) begin
                        state_nx = RHI;
                        cnt_load = 1'b1;
                        cnt_val  = SET_V;
                    end else begin
                        state_nx = RSP;
                    end
                end
            end
            RSP: begin
                valid_nx = !(RSP_VALID && RSP_READY);
                if (RSP_VALID && RSP_READY) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // registered bus strobes; read bytes sampled on the last N_OE-low cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            BUS_OE      <= 1'b0;
            BUS_OUT     <= '0;
            LATCH_CLK1  <= CLK_IDLE;
            LATCH_CLK2  <= CLK_IDLE;
            LATCH_N_OE1 <= N_OE_OFF;
            LATCH_N_OE2 <= N_OE_OFF;
            RSP_VALID   <= 1'b0;
            RSP_DATA    <= '0;
        end else begin
            BUS_OE      <= oe_nx;
            BUS_OUT     <= out_nx;
            LATCH_CLK1  <= clk1_nx;
            LATCH_CLK2  <= clk2_nx;
            LATCH_N_OE1 <= noe1_nx;
            LATCH_N_OE2 <= noe2_nx;
            RSP_VALID   <= valid_nx;
            if (accept) begin
                RSP_DATA <= '0;
            end else if (!LATCH_N_OE1 && noe1_nx) begin
                RSP_DATA[7:0] <= BUS_IN;
            end else if (!LATCH_N_OE2 && noe2_nx) begin
                RSP_DATA[15:8] <= BUS_IN;
            end
        end
    end

endmodule

// File: tb/tb_reg16_bus_ctrl.sv
// tb_reg16_bus_ctrl: directed and random transactions against two
// controllers (default timing and SETTLE=TURNAROUND=2) with latch models.
module tb_reg16_bus_ctrl;

    typedef struct {
        logic [15:0] data;
        int          lat;
    } exp_t;

    localparam logic [7:0] FLOAT = 8'hEE;

    logic        clk;
    logic        rst;

    logic        a_req_valid, a_req_write, a_rsp_ready;
    logic [15:0] a_req_data;
    logic        a_req_ready, a_rsp_valid, a_bus_oe;
    logic        a_lclk1, a_lclk2, a_noe1, a_noe2;
    logic [15:0] a_rsp_data;
    logic [7:0]  a_bus_out, a_bus_in, a_lat1, a_lat2;

    logic        b_req_valid, b_req_write, b_rsp_ready;
    logic [15:0] b_req_data;
    logic        b_req_ready, b_rsp_valid, b_bus_oe;
    logic        b_lclk1, b_lclk2, b_noe1, b_noe2;
    logic [15:0] b_rsp_data;
    logic [7:0]  b_bus_out, b_bus_in, b_lat1, b_lat2;

    exp_t        sb[$];
    int          n_vec, n_err;
    logic [10:0] pa, pb;
    int          a_r1, a_r2, a_n1, a_n2;
    int          b_r1, b_r2, b_n1, b_n2;

    reg16_bus_ctrl dut_a (
        .CLK(clk), .RST(rst),
        .REQ_VALID(a_req_valid), .REQ_READY(a_req_ready),
        .REQ_WRITE(a_req_write), .REQ_DATA(a_req_data),
        .RSP_VALID(a_rsp_valid), .RSP_READY(a_rsp_ready),
        .RSP_DATA(a_rsp_data),
        .BUS_OUT(a_bus_out), .BUS_OE(a_bus_oe), .BUS_IN(a_bus_in),
        .LATCH_CLK1(a_lclk1), .LATCH_CLK2(a_lclk2),
        .LATCH_N_OE1(a_noe1), .LATCH_N_OE2(a_noe2)
    );

    reg16_bus_ctrl #(.SETTLE(2), .TURNAROUND(2)) dut_b (
        .CLK(clk), .RST(rst),
        .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready),
        .REQ_WRITE(b_req_write), .REQ_DATA(b_req_data),
        .RSP_VALID(b_rsp_valid), .RSP_READY(b_rsp_ready),
        .RSP_DATA(b_rsp_data),
        .BUS_OUT(b_bus_out), .BUS_OE(b_bus_oe), .BUS_IN(b_bus_in),
        .LATCH_CLK1(b_lclk1), .LATCH_CLK2(b_lclk2),
        .LATCH_N_OE1(b_noe1), .LATCH_N_OE2(b_noe2)
    );

    assign a_bus_in = a_bus_oe ? a_bus_out : !a_noe1 ? a_lat1 : !a_noe2 ? a_lat2 : FLOAT;
    assign b_bus_in = b_bus_oe ? b_bus_out : !b_noe1 ? b_lat1 : !b_noe2 ? b_lat2 : FLOAT;

    always @(posedge a_lclk1) a_lat1 <= a_bus_in;
    always @(posedge a_lclk2) a_lat2 <= a_bus_in;
    always @(posedge b_lclk1) b_lat1 <= b_bus_in;
    always @(posedge b_lclk2) b_lat2 <= b_bus_in;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic inv(input string t, input logic oe, input logic n1, input logic n2,
                       input logic c1, input logic c2, input logic [7:0] out,
                       input logic [10:0] p);
        check({t, "_contention"}, 32'(oe && (!n1 || !n2)), 32'd0);
        check({t, "_noe_both_low"}, 32'(!n1 && !n2), 32'd0);
        check({t, "_clk_width"}, 32'((c1 && p[9]) || (c2 && p[8])), 32'd0);
        check({t, "_clk1_setup"}, 32'(c1 && !p[9] && !(p[10] && (p[7:0] == out))), 32'd0);
        check({t, "_clk2_setup"}, 32'(c2 && !p[8] && !(p[10] && (p[7:0] == out))), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        inv("a", a_bus_oe, a_noe1, a_noe2, a_lclk1, a_lclk2, a_bus_out, pa);
        inv("b", b_bus_oe, b_noe1, b_noe2, b_lclk1, b_lclk2, b_bus_out, pb);
        if (a_lclk1 && !pa[9]) a_r1++;
        if (a_lclk2 && !pa[8]) a_r2++;
        if (!a_noe1) a_n1++;
        if (!a_noe2) a_n2++;
        if (b_lclk1 && !pb[9]) b_r1++;
        if (b_lclk2 && !pb[8]) b_r2++;
        if (!b_noe1) b_n1++;
        if (!b_noe2) b_n2++;
        pa = {a_bus_oe, a_lclk1, a_lclk2, a_bus_out};
        pb = {b_bus_oe, b_lclk1, b_lclk2, b_bus_out};
    endtask

    task automatic set_req(input bit s, input logic v, input logic w, input logic [15:0] d);
        if (s) begin
            b_req_valid = v; b_req_write = w; b_req_data = d;
        end else begin
            a_req_valid = v; a_req_write = w; a_req_data = d;
        end
    endtask

    task automatic set_rdy(input bit s, input logic r);
        if (s) b_rsp_ready = r;
        else a_rsp_ready = r;
    endtask

    task automatic txn(input bit s, input logic wr, input logic [15:0] d,
                       input logic [15:0] ed, input int lat, input int hold, input bit early);
        exp_t        e;
        int          n;
        int          low_exp;
        logic [15:0] snap;
        sb.push_back(exp_t'{data: ed, lat: lat});
        a_r1 = 0; a_r2 = 0; a_n1 = 0; a_n2 = 0;
        b_r1 = 0; b_r2 = 0; b_n1 = 0; b_n2 = 0;
        check("req_ready_idle", 32'(s ? b_req_ready : a_req_ready), 32'd1);
        set_req(s, 1'b1, wr, d);
        set_rdy(s, early);
        tick();
        set_req(s, 1'b0, wr, d);
        n = 0;
        while (!(s ? b_rsp_valid : a_rsp_valid) && n < 40) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        check("rsp_latency", n, e.lat);
        snap = s ? b_rsp_data : a_rsp_data;
        check("rsp_data", 32'(snap), 32'(e.data));
        for (int h = 0; h < hold; h++) begin
            set_req(s, 1'b1, ~wr, 16'hDEAD);
            tick();
            check("hold_valid", 32'(s ? b_rsp_valid : a_rsp_valid), 32'd1);
            check("hold_data", 32'(s ? b_rsp_data : a_rsp_data), 32'(snap));
            check("hold_req_ready", 32'(s ? b_req_ready : a_req_ready), 32'd0);
        end
        set_rdy(s, 1'b1);
        tick();
        set_rdy(s, 1'b0);
        set_req(s, 1'b0, wr, d);
        check("rsp_dropped", 32'(s ? b_rsp_valid : a_rsp_valid), 32'd0);
        check("req_ready_back", 32'(s ? b_req_ready : a_req_ready), 32'd1);
        low_exp = wr ? 0 : (s ? 3 : 2);
        check("clk1_pulses", s ? b_r1 : a_r1, wr ? 1 : 0);
        check("clk2_pulses", s ? b_r2 : a_r2, wr ? 1 : 0);
        check("noe1_low_cycles", s ? b_n1 : a_n1, low_exp);
        check("noe2_low_cycles", s ? b_n2 : a_n2, low_exp);
    endtask

    initial begin
        int          n;
        logic        w;
        logic [15:0] d;
        logic [15:0] model;
        int          hold;
        bit          early;

        n_vec = 0; n_err = 0;
        pa = '0; pb = '0;
        a_r1 = 0; a_r2 = 0; a_n1 = 0; a_n2 = 0;
        b_r1 = 0; b_r2 = 0; b_n1 = 0; b_n2 = 0;
        rst = 1'b1;
        a_req_valid = 0; a_req_write = 0; a_req_data = '0; a_rsp_ready = 0;
        b_req_valid = 0; b_req_write = 0; b_req_data = '0; b_rsp_ready = 0;
        model = '0;

        tick();
        tick();
        check("rst_req_ready_a", 32'(a_req_ready), 32'd0);
        check("rst_req_ready_b", 32'(b_req_ready), 32'd0);
        check("rst_rsp_valid", 32'({a_rsp_valid, b_rsp_valid}), 32'd0);
        check("rst_rsp_data", 32'({a_rsp_data, b_rsp_data}), 32'd0);
        check("rst_bus_out", 32'({a_bus_out, b_bus_out}), 32'd0);
        check("rst_bus_oe", 32'({a_bus_oe, b_bus_oe}), 32'd0);
        check("rst_latch_clk", 32'({a_lclk1, a_lclk2, b_lclk1, b_lclk2}), 32'd0);
        check("rst_n_oe", 32'({a_noe1, a_noe2, b_noe1, b_noe2}), 32'hF);
        rst = 1'b0;
        #1;
        check("post_rst_ready_a", 32'(a_req_ready), 32'd1);
        check("post_rst_ready_b", 32'(b_req_ready), 32'd1);

        txn(0, 1'b1, 16'hA55A, 16'h0000, 6, 0, 0);
        check("latch1_a55a", 32'(a_lat1), 32'h5A);
        check("latch2_a55a", 32'(a_lat2), 32'hA5);

        txn(0, 1'b1, 16'h1234, 16'h0000, 6, 0, 0);
        txn(0, 1'b0, 16'h0000, 16'h1234, 7, 0, 0);

        txn(1, 1'b1, 16'hBEEF, 16'h0000, 7, 0, 0);
        txn(1, 1'b0, 16'h0000, 16'hBEEF, 11, 0, 0);

        txn(0, 1'b0, 16'h0000, 16'h1234, 7, 5, 0);
        txn(0, 1'b1, 16'h0F0F, 16'h0000, 6, 0, 1);
        txn(0, 1'b0, 16'h0000, 16'h0F0F, 7, 0, 1);

        set_req(0, 1'b1, 1'b1, 16'h7788);
        tick();
        set_req(0, 1'b0, 1'b1, 16'h7788);
        n = 0;
        while (!(a_bus_oe && a_bus_out == 8'h77 && !a_lclk2) && n < 20) begin
            tick();
            n++;
        end
        check("rst_reach_whi_stb", n, 3);
        rst = 1'b1;
        #1;
        check("rst_cycle_ready", 32'(a_req_ready), 32'd0);
        tick();
        check("rst_mid_clk2", 32'(a_lclk2), 32'd0);
        check("rst_mid_clk1", 32'(a_lclk1), 32'd0);
        check("rst_mid_oe", 32'(a_bus_oe), 32'd0);
        check("rst_mid_noe", 32'({a_noe1, a_noe2}), 32'd3);
        rst = 1'b0;
        #1;
        check("rst_mid_ready", 32'(a_req_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_no_rsp", 32'(a_rsp_valid), 32'd0);
        end
        check("rst_latch1_kept", 32'(a_lat1), 32'h88);
        check("rst_latch2_kept", 32'(a_lat2), 32'h0F);

        for (int i = 0; i < 24; i++) begin
            w     = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            d     = 16'($urandom());
            early = 1'($urandom_range(0, 1));
            hold  = early ? 0 : int'($urandom_range(0, 2));
            if (w) begin
                txn(0, 1'b1, d, 16'h0000, 6, hold, early);
                model = d;
            end else begin
                txn(0, 1'b0, 16'h0000, model, 7, hold, early);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg16_bus_ctrl.md
# reg16_bus_ctrl

- Bus master for a pair of 8-bit edge-triggered latches with tristate outputs that share one 8-bit data bus.
- Turns a 16-bit read or write request into the strobe sequence the latches need:
  - writes drive each bus byte and pulse the matching latch clock;
  - reads enable each latch's output in turn and sample the bus.
- Sits between the CPU-side register file logic and the board-level latch pair, owning bus direction and turnaround.

## Interface

Parameters:
- SETTLE, default 1: extra cycles a latch output enable is held low before the bus is sampled (≥0).
- TURNAROUND, default 1: idle cycles with no bus driver between driver changes (≥1).

Ports:
- CLK  in  1  sole clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  controller can accept a request.
- REQ_WRITE  in  1  1 = write, 0 = read.
- REQ_DATA  in  16  write data: [7:0] to latch 1, [15:8] to latch 2.
- RSP_VALID  out  1  transaction complete.
- RSP_READY  in  1  response consumed.
- RSP_DATA  out  16  read data; 0 for writes.
- BUS_OUT  out  8  byte driven by the controller.
- BUS_OE  out  1  controller drives the bus when 1.
- BUS_IN  in  8  resolved bus value.
- LATCH_CLK1, LATCH_CLK2  out  1 each  latch clocks, pulsed high.
- LATCH_N_OE1, LATCH_N_OE2  out  1 each  active-low latch output enables.

## Operation

- All outputs are registered. REQ_READY is the only exception: it is high exactly in IDLE.
- A request is accepted on an edge with REQ_VALID && REQ_READY. REQ_WRITE and REQ_DATA are captured on that edge.

States:
- IDLE.
- WLO_SET: BUS_OE=1, BUS_OUT=d[7:0].
- WLO_STB: as WLO_SET, plus LATCH_CLK1=1.
- WHI_SET: BUS_OUT=d[15:8], LATCH_CLK1=0.
- WHI_STB: LATCH_CLK2=1.
- RLO: LATCH_N_OE1=0 for SETTLE+1 cycles; BUS_IN is captured into RSP_DATA[7:0] on the last one.
- RHI: the same with LATCH_N_OE2 into RSP_DATA[15:8].
- TURN: TURNAROUND cycles with BUS_OE=0 and both N_OE high.
- RSP.

Transitions:
- Write: IDLE→WLO_SET→WLO_STB→WHI_SET→WHI_STB→TURN→RSP.
- Read: IDLE→RLO→TURN→RHI→TURN→RSP.
- RSP holds RSP_VALID=1 and RSP_DATA stable until RSP_READY, then goes to IDLE.

Reset:
- Values: REQ_READY=0 during the reset cycle and 1 after; RSP_VALID=0; RSP_DATA=0; BUS_OUT=0; BUS_OE=0; LATCH_CLK1/2=0; LATCH_N_OE1/2=1; state IDLE.
- Reset mid-transaction: every strobe is inactive in the next cycle and the transaction and its response are discarded.

Invariants:
- BUS_OE=1 never coincides with either N_OE low.
- N_OE1 and N_OE2 are never low together.
- Each latch clock is high for exactly one cycle per write, with its data already on the bus for at least one cycle before the rising edge.
- BUS_OUT changes only while the corresponding LATCH_CLK is low.

## Timing

- Accepting edge = cycle 0.
- Write: RSP_VALID first high in cycle 5+TURNAROUND (default 6).
- Read: RSP_VALID first high in cycle 2·(SETTLE+1)+2·TURNAROUND+1 (default 7).
- Throughput:
  - at most one transaction outstanding;
  - REQ_VALID while busy is held off by REQ_READY=0;
  - the next acceptance is earliest in the cycle after RSP_READY is sampled with RSP_VALID.
- RSP_READY high before RSP_VALID has no effect. It is only honoured in RSP.
- SETTLE=0: the N_OE low cycle is also the sample cycle.

## Structure

- Package reg16_bus_pkg: state enum (IDLE, WLO_SET, WLO_STB, WHI_SET, WHI_STB, RLO, RHI, TURN, RSP) and the shared strobe constants (N_OE_OFF=1, CLK_IDLE=0).
- A one-bit flag records whether TURN returns to RHI or RSP.
- Sub-module bus_wait_cnt:
  - loadable down-counter for SETTLE and TURNAROUND;
  - inputs: load value and enable;
  - output: single-cycle `done`;
  - width is $clog2 of the larger parameter plus 1.

## Test plan

- Write 16'hA55A with default parameters:
  - latch 1 captures 8'h5A on the LATCH_CLK1 rise and latch 2 captures 8'hA5 on the LATCH_CLK2 rise;
  - RSP_VALID rises in cycle 6;
  - RSP_DATA=0.
- Write 16'h1234, then read with bus models backing the latches: RSP_DATA=16'h1234 in cycle 7 after the read is accepted.
- Read with SETTLE=2, TURNAROUND=2: N_OE1 is low for 3 cycles, N_OE2 is low for 3 cycles, and RSP_VALID arrives in cycle 11.
- Hold RSP_READY=0 for 5 cycles:
  - RSP_VALID and RSP_DATA stay stable;
  - REQ_READY stays 0 and a second REQ_VALID is not accepted until after RSP_READY.
- Assert RST in WHI_STB:
  - next cycle LATCH_CLK2=0, BUS_OE=0 and both N_OE=1;
  - no RSP_VALID follows;
  - REQ_READY=1 the cycle after reset deasserts.
- Random back-to-back reads and writes: assertion checks hold every cycle (no bus contention, one-hot N_OE, one-cycle clock pulses).
